// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for controllers that borrow the execute-stage ALU:
//   - XLEN        : datapath / ALU width
//   - ALU_*       : 4-bit ALU control codes (ADD and COMP used by the
//                   multiply sequencer, the rest used by other controllers)
//   - seq_state_t : multiply sequencer state encoding
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_COMP = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_NEG_A  = 3'd1,
        SEQ_NEG_B  = 3'd2,
        SEQ_ITER   = 3'd3,
        SEQ_FIX_LO = 3'd4,
        SEQ_FIX_HI = 3'd5,
        SEQ_DONE   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer_if
// Bundles the multiply request/response handshake and the shared ALU port.
//   master : execute stage + ALU (drives request, operands, ALU result)
//   slave  : multiply sequencer (drives status, product, ALU inputs)
// Signals: start, is_signed, op_a, op_b, busy, done, result_hi, result_lo,
//          alu_in1, alu_in2, alu_shamt, alu_ctrl, alu_out, alu_carry
// ---------------------------------------------------------------------------
interface alu_mul_sequencer_if;

    logic                           start;
    logic                           is_signed;
    logic [alu_ctrl_pkg::XLEN-1:0]  op_a;
    logic [alu_ctrl_pkg::XLEN-1:0]  op_b;
    logic                           busy;
    logic                           done;
    logic [alu_ctrl_pkg::XLEN-1:0]  result_hi;
    logic [alu_ctrl_pkg::XLEN-1:0]  result_lo;
    logic [alu_ctrl_pkg::XLEN-1:0]  alu_in1;
    logic [alu_ctrl_pkg::XLEN-1:0]  alu_in2;
    logic [4:0]                     alu_shamt;
    logic [3:0]                     alu_ctrl;
    logic [alu_ctrl_pkg::XLEN-1:0]  alu_out;
    logic                           alu_carry;

    modport master (
        output start, is_signed, op_a, op_b, alu_out, alu_carry,
        input  busy, done, result_hi, result_lo,
               alu_in1, alu_in2, alu_shamt, alu_ctrl
    );

    modport slave (
        input  start, is_signed, op_a, op_b, alu_out, alu_carry,
        output busy, done, result_hi, result_lo,
               alu_in1, alu_in2, alu_shamt, alu_ctrl
    );

endinterface

// File: rtl/alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// alu_mul_sequencer
// Fixed-latency 32x32->64 multiplier built on the shared ALU (ADD/COMP only,
// one ALU op per cycle). Signed operands are converted to magnitudes, an
// unsigned shift-add loop runs, and the product is negated if needed.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : request/response handshake and ALU port (slave side)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// SEQ_IDLE   | waiting for start, ALU inputs parked at 0 / ADD
// SEQ_NEG_A  | COMP on multiplicand, keep magnitude, record sign_a
// SEQ_NEG_B  | COMP on multiplier (acc_lo), record product sign
// SEQ_ITER   | one shift-add step per cycle, ITERS cycles
// SEQ_FIX_LO | COMP on low word, select if product is negative
// SEQ_FIX_HI | COMP or invert high word depending on low word being zero
// SEQ_DONE   | one-cycle done pulse, results already registered
// ---------------------------------------------------------------------------
module alu_mul_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN  = alu_ctrl_pkg::XLEN,
    parameter int ITERS = XLEN
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_mul_sequencer_if.slave  bus
);

    localparam int               CNT_W     = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    seq_state_t         r_state;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_acc_hi;
    logic [XLEN-1:0]    r_acc_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_signed;
    logic               r_sign_a;
    logic               r_neg_res;
    logic               r_lo_zero;
    logic               r_busy;
    logic               r_done;
    logic [XLEN-1:0]    r_res_hi;
    logic [XLEN-1:0]    r_res_lo;

    logic [XLEN-1:0]    w_alu_in1;
    logic [XLEN-1:0]    w_alu_in2;
    logic [3:0]         w_alu_ctrl;
    logic [XLEN-1:0]    w_h;
    logic               w_c;
    logic [XLEN-1:0]    w_acc_hi_nxt;
    logic [XLEN-1:0]    w_acc_lo_nxt;

    always_comb begin
        w_alu_in1  = '0;
        w_alu_in2  = '0;
        w_alu_ctrl = ALU_ADD;
        case (r_state)
            SEQ_NEG_A: begin
                w_alu_ctrl = ALU_COMP;
                w_alu_in1  = r_a;
            end
            SEQ_NEG_B, SEQ_FIX_LO: begin
                w_alu_ctrl = ALU_COMP;
                w_alu_in1  = r_acc_lo;
            end
            SEQ_ITER: begin
                w_alu_ctrl = ALU_ADD;
                w_alu_in1  = r_acc_hi;
                w_alu_in2  = r_a;
            end
            SEQ_FIX_HI: begin
                w_alu_ctrl = ALU_COMP;
                w_alu_in1  = r_acc_hi;
            end
            default: ;
        endcase
    end

    // Next accumulator values; shared by the state updates and by the result
    // registers so the product is visible in the same cycle as done.
    always_comb begin
        w_h          = r_acc_lo[0] ? bus.alu_out : r_acc_hi;
        w_c          = r_acc_lo[0] & bus.alu_carry;
        w_acc_hi_nxt = r_acc_hi;
        w_acc_lo_nxt = r_acc_lo;
        case (r_state)
            SEQ_NEG_B: begin
                if (r_acc_lo[XLEN-1]) w_acc_lo_nxt = bus.alu_out;
            end
            SEQ_ITER: begin
                w_acc_hi_nxt = {w_c, w_h[XLEN-1:1]};
                w_acc_lo_nxt = {w_h[0], r_acc_lo[XLEN-1:1]};
            end
            SEQ_FIX_LO: begin
                if (r_neg_res) w_acc_lo_nxt = bus.alu_out;
            end
            SEQ_FIX_HI: begin
                // Borrow from the low word only propagates when it was zero;
                // otherwise the high word negation is a plain invert.
                if (r_neg_res) w_acc_hi_nxt = r_lo_zero ? bus.alu_out : ~r_acc_hi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= SEQ_IDLE;
            r_a       <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
            r_signed  <= 1'b0;
            r_sign_a  <= 1'b0;
            r_neg_res <= 1'b0;
            r_lo_zero <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_res_hi  <= '0;
            r_res_lo  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                SEQ_IDLE: begin
                    if (bus.start) begin
                        r_a      <= bus.op_a;
                        r_acc_lo <= bus.op_b;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                        r_signed <= bus.is_signed;
                        r_busy   <= 1'b1;
                        r_state  <= bus.is_signed ? SEQ_NEG_A : SEQ_ITER;
                    end
                end
                SEQ_NEG_A: begin
                    r_sign_a <= r_a[XLEN-1];
                    if (r_a[XLEN-1]) r_a <= bus.alu_out;
                    r_state  <= SEQ_NEG_B;
                end
                SEQ_NEG_B: begin
                    r_neg_res <= r_sign_a ^ r_acc_lo[XLEN-1];
                    r_acc_lo  <= w_acc_lo_nxt;
                    r_state   <= SEQ_ITER;
                end
                SEQ_ITER: begin
                    r_acc_hi <= w_acc_hi_nxt;
                    r_acc_lo <= w_acc_lo_nxt;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_ITER) begin
                        if (r_signed) begin
                            r_state <= SEQ_FIX_LO;
                        end else begin
                            r_res_hi <= w_acc_hi_nxt;
                            r_res_lo <= w_acc_lo_nxt;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= SEQ_DONE;
                        end
                    end
                end
                SEQ_FIX_LO: begin
                    r_lo_zero <= (r_acc_lo == '0);
                    r_acc_lo  <= w_acc_lo_nxt;
                    r_state   <= SEQ_FIX_HI;
                end
                SEQ_FIX_HI: begin
                    r_acc_hi <= w_acc_hi_nxt;
                    r_res_hi <= w_acc_hi_nxt;
                    r_res_lo <= w_acc_lo_nxt;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= SEQ_DONE;
                end
                SEQ_DONE: begin
                    r_state <= SEQ_IDLE;
                end
                default: begin
                    r_state <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result_hi = r_res_hi;
    assign bus.result_lo = r_res_lo;
    assign bus.alu_in1   = w_alu_in1;
    assign bus.alu_in2   = w_alu_in2;
    assign bus.alu_shamt = 5'd0;
    assign bus.alu_ctrl  = w_alu_ctrl;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_mul_sequencer
// Drives directed and random multiplies through alu_mul_sequencer with a
// behavioural ALU, and compares product, latency, busy/done behaviour and
// ALU usage against a plain-arithmetic reference.
// ---------------------------------------------------------------------------
module tb_alu_mul_sequencer;
    import alu_ctrl_pkg::*;

    logic clk;
    logic rst_n;

    alu_mul_sequencer_if u_if();

    alu_mul_sequencer #(.XLEN(32), .ITERS(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU
    always_comb begin
        u_if.alu_out   = '0;
        u_if.alu_carry = 1'b0;
        if (u_if.alu_ctrl == ALU_ADD)
            {u_if.alu_carry, u_if.alu_out} = {1'b0, u_if.alu_in1} + {1'b0, u_if.alu_in2};
        else if (u_if.alu_ctrl == ALU_COMP)
            u_if.alu_out = 32'd0 - u_if.alu_in1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sgn) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input bit inject, input string tag);
        logic [63:0] exp;
        int lat, busy_cnt, comp_cnt, shamt_bad;
        exp = ref_mul(sgn, a, b);
        @(negedge clk);
        u_if.start = 1'b1; u_if.is_signed = sgn; u_if.op_a = a; u_if.op_b = b;
        @(posedge clk);
        @(negedge clk);
        u_if.start = 1'b0; u_if.is_signed = 1'($urandom);
        u_if.op_a = $urandom; u_if.op_b = $urandom;
        lat = 0; busy_cnt = 0; comp_cnt = 0; shamt_bad = 0;
        while (!u_if.done && lat < 100) begin
            if (u_if.busy) busy_cnt++;
            if (u_if.alu_ctrl == ALU_COMP) comp_cnt++;
            if (u_if.alu_shamt != 5'd0) shamt_bad++;
            if (inject && (lat == 1 || lat == 20)) begin
                u_if.start = 1'b1; u_if.is_signed = 1'($urandom);
                u_if.op_a = $urandom; u_if.op_b = $urandom;
            end else begin
                u_if.start = 1'b0;
            end
            @(posedge clk); lat++;
            @(negedge clk);
        end
        u_if.start = 1'b0;
        check({tag, " latency"}, 64'(lat), sgn ? 64'd36 : 64'd32);
        check({tag, " busy_cycles"}, 64'(busy_cnt), sgn ? 64'd36 : 64'd32);
        check({tag, " comp_ops"}, 64'(comp_cnt), sgn ? 64'd4 : 64'd0);
        check({tag, " shamt"}, 64'(shamt_bad), 64'd0);
        check({tag, " busy_at_done"}, 64'(u_if.busy), 64'd0);
        check({tag, " product"}, {u_if.result_hi, u_if.result_lo}, exp);
        @(posedge clk); @(negedge clk);
        check({tag, " done_pulse"}, 64'(u_if.done), 64'd0);
        check({tag, " result_hold"}, {u_if.result_hi, u_if.result_lo}, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen_done;
        rst_n = 1'b0;
        u_if.start = 1'b0; u_if.is_signed = 1'b0; u_if.op_a = '0; u_if.op_b = '0;
        repeat (3) @(negedge clk);
        check("rst busy", 64'(u_if.busy), 64'd0);
        check("rst done", 64'(u_if.done), 64'd0);
        check("rst result", {u_if.result_hi, u_if.result_lo}, 64'd0);
        check("rst alu_in", {u_if.alu_in1, u_if.alu_in2}, 64'd0);
        check("rst alu_ctrl", 64'(u_if.alu_ctrl), 64'(ALU_ADD));
        check("rst shamt", 64'(u_if.alu_shamt), 64'd0);
        rst_n = 1'b1;

        run_mul(1'b0, 32'd3, 32'd5, 1'b0, "u3x5");
        run_mul(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "uFFxFF");
        run_mul(1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0, "s-3x7");
        run_mul(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, "sMINxMIN");
        run_mul(1'b1, 32'hFFFF_FFFF, 32'd0, 1'b0, "s-1x0");
        run_mul(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, "u_ignore_start");
        run_mul(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, "s_ignore_start");

        // Abort an operation with reset partway through
        @(negedge clk);
        u_if.start = 1'b1; u_if.is_signed = 1'b0;
        u_if.op_a = 32'h0001_2345; u_if.op_b = 32'h0000_0777;
        @(posedge clk);
        @(negedge clk);
        u_if.start = 1'b0;
        repeat (10) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(u_if.busy), 64'd0);
        check("abort done", 64'(u_if.done), 64'd0);
        check("abort result", {u_if.result_hi, u_if.result_lo}, 64'd0);
        seen_done = 0;
        repeat (2) begin @(negedge clk); if (u_if.done) seen_done++; end
        rst_n = 1'b1;
        repeat (40) begin @(negedge clk); if (u_if.done || u_if.busy) seen_done++; end
        check("abort no_done", 64'(seen_done), 64'd0);
        run_mul(1'b0, 32'd6, 32'd7, 1'b0, "u6x7_after_rst");

        for (int i = 0; i < 24; i++) begin
            logic sg;
            logic [31:0] ra, rb;
            sg = 1'($urandom);
            ra = pick_op();
            rb = pick_op();
            run_mul(sg, ra, rb, (i % 5) == 0, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes a 32x32 -> 64-bit product using only the shared combinational ALU's ADD (4'b0000) and COMP (4'b0001) operations, with one ALU operation per cycle.
- Sits beside the execute stage; owns the ALU input mux while busy.
- Supports unsigned and signed (two's complement) operands.
- Fixed, operand-independent latency to simplify pipeline stall logic.

Parameters:
- XLEN, 32, operand width; must equal the ALU width.
- ITERS, 32, shift-add iterations; must equal XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  1 = signed multiply; latched with start
- op_a  in  32  multiplicand; latched with start
- op_b  in  32  multiplier; latched with start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- result_hi  out  32  product[63:32]
- result_lo  out  32  product[31:0]
- alu_in1  out  32  ALU input1
- alu_in2  out  32  ALU input2
- alu_shamt  out  5  ALU shamt; always 0
- alu_ctrl  out  4  ALU control signal
- alu_out  in  32  ALU result, combinational from the alu_* outputs
- alu_carry  in  1  ALU carry; meaningful only when alu_ctrl = ADD

Behaviour:
- Reset (async, rst_n = 0): state = IDLE. busy, done, result_hi, result_lo, alu_in1, alu_in2, alu_shamt = 0. alu_ctrl = ADD. All internal registers = 0. Applies mid-operation; the operation in flight is abandoned with no done pulse.
- States: IDLE, NEG_A, NEG_B, ITER, FIX_LO, FIX_HI, DONE.
- IDLE:
  - On start = 1, latch operands and is_signed, clear acc_hi, set cnt = 0.
  - Next state: NEG_A if signed, else ITER.
  - start while not in IDLE is ignored (not queued).
- NEG_A:
  - Drive alu_ctrl = COMP, alu_in1 = a.
  - If a[31], replace a with alu_out. Record sign_a.
- NEG_B:
  - Same as NEG_A for b. Record neg_res = sign_a ^ sign_b.
  - b becomes acc_lo.
- ITER (one cycle per iteration):
  - Drive ADD with alu_in1 = acc_hi, alu_in2 = a.
  - If acc_lo[0]: {c, h} = {alu_carry, alu_out}. Else {c, h} = {0, acc_hi}.
  - Update acc_hi = {c, h[31:1]} and acc_lo = {h[0], acc_lo[31:1]}.
  - cnt++. After iteration ITERS-1: go to FIX_LO if signed, else DONE.
- FIX_LO:
  - Drive COMP on acc_lo.
  - If neg_res, acc_lo = alu_out. Record lo_zero = (original acc_lo == 0).
- FIX_HI:
  - Drive COMP on acc_hi.
  - If neg_res: acc_hi = lo_zero ? alu_out : ~acc_hi.
- DONE:
  - Register result_hi/lo from the accumulators. done = 1 and busy = 0 for exactly one cycle.
  - Return to IDLE. start is not accepted in DONE.
- Signed passes always traverse NEG_A, NEG_B, FIX_LO and FIX_HI; the ALU op is issued every time and its result is selected only when needed. This keeps latency fixed.
- Latency:
  - Start accepted at edge k. busy = 1 after edge k.
  - done = 1 after edge k+32 (unsigned) or k+36 (signed).
  - A new start is accepted at the edge ending the cycle after done.
- result_hi/lo hold their value until the next DONE or reset.
- The alu_* outputs are combinational from state/registers. The ALU result is consumed in the same cycle; no ALU pipeline register.
- op_a = 0x80000000, signed: COMP yields 0x80000000, which is correct as an unsigned magnitude. No overflow flag is needed; the product always fits in 64 bits.

Decomposition:
- Shared package alu_ctrl_pkg:
  - ALU opcode constants: ALU_ADD = 4'b0000, ALU_COMP = 4'b0001, plus the remaining 4-bit codes for other controllers.
  - Sequencer state enum.
  - XLEN constant.
- No sub-module: a single FSM with an accumulator datapath in one module.

Test Plan:
1. Unsigned 3 x 5 -> result_lo = 0x0000000F, result_hi = 0. done exactly 32 cycles after the start edge. busy high for 32 cycles.
2. Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. Checks that carry capture is exercised every iteration.
3. Signed -3 x 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. done at 36 cycles. alu_ctrl = COMP in NEG_A, NEG_B, FIX_LO and FIX_HI.
4. Signed 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0. Signed -1 x 0 -> hi = 0, lo = 0 (lo_zero path).
5. start pulsed at busy cycles 1 and 20 with different operands -> ignored; the first operands' product is returned, single done pulse.
6. rst_n low at cycle 10 of an operation -> busy, done and results go to 0 immediately with no done pulse. A subsequent start (6 x 7 unsigned) -> lo = 42 after 32 cycles.
